// File: rtl/switch_nport_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : switch_nport_pkg
//  Description : Width-independent helpers for the N-port address switch:
//                port-select width, destination decode and counter width.
//  Revision    : 1.0 - initial release
// ============================================================================
package switch_nport_pkg;

    // Width of each per-port push counter (SWITCH_CNT_EN builds only)
    localparam int CNT_WIDTH = 16;

    // Number of address bits needed to select one of num_ports egress ports
    function automatic int port_bits(input int num_ports);
        return $clog2(num_ports);
    endfunction

    // Destination port = the top pbits bits of an addr_width-bit address
    function automatic int unsigned dest_index(input logic [63:0] addr,
                                               input int          addr_width,
                                               input int          pbits);
        logic [63:0] w_sh;
        logic [63:0] w_mask;
        w_sh   = addr >> (addr_width - pbits);
        w_mask = (64'd1 << pbits) - 64'd1;
        return 32'(w_sh & w_mask);
    endfunction

endpackage : switch_nport_pkg
`default_nettype wire

// File: rtl/switch_nport_if.sv
`default_nettype none
// ============================================================================
//  Module      : switch_nport_if
//  Description : Ingress stream plus NUM_PORTS flattened egress streams of
//                the N-port switch. out_cnt exists only when SWITCH_CNT_EN
//                is defined.
//  Revision    : 1.0 - initial release
// ============================================================================
interface switch_nport_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4
);
    import switch_nport_pkg::*;

    logic                           in_vld;
    logic                           in_rdy;
    logic [ADDR_WIDTH-1:0]          in_addr;
    logic [DATA_WIDTH-1:0]          in_data;
    logic [NUM_PORTS-1:0]           out_vld;
    logic [NUM_PORTS-1:0]           out_rdy;
    logic [NUM_PORTS*ADDR_WIDTH-1:0] out_addr;
    logic [NUM_PORTS*DATA_WIDTH-1:0] out_data;
`ifdef SWITCH_CNT_EN
    logic [NUM_PORTS*CNT_WIDTH-1:0] out_cnt;

    // Environment side: drives ingress beats and egress ready
    modport master (
        output in_vld, in_addr, in_data, out_rdy,
        input  in_rdy, out_vld, out_addr, out_data, out_cnt
    );

    // Switch side
    modport slave (
        input  in_vld, in_addr, in_data, out_rdy,
        output in_rdy, out_vld, out_addr, out_data, out_cnt
    );
`else
    // Environment side: drives ingress beats and egress ready
    modport master (
        output in_vld, in_addr, in_data, out_rdy,
        input  in_rdy, out_vld, out_addr, out_data
    );

    // Switch side
    modport slave (
        input  in_vld, in_addr, in_data, out_rdy,
        output in_rdy, out_vld, out_addr, out_data
    );
`endif

endinterface : switch_nport_if
`default_nettype wire

// File: rtl/switch_nport_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : switch_nport_fifo
//  Description : Synchronous first-word-fall-through FIFO. Pointers carry
//                one extra wrap bit so full/empty come from a pointer compare.
//                Push while full and pop while empty are ignored.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_nport_fifo #(
    parameter int WIDTH = 24,
    parameter int DEPTH = 4
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] din,
    input  wire logic             pop,
    output logic                  full,
    output logic                  empty,
    output logic      [WIDTH-1:0] head
);

    localparam int c_PTR_W = $clog2(DEPTH);

    logic [c_PTR_W:0]   r_wr_ptr;
    logic [c_PTR_W:0]   r_rd_ptr;
    logic [WIDTH-1:0]   r_mem [DEPTH];
    logic               w_do_push;
    logic               w_do_pop;

    // Equal index with opposite wrap bits means every slot is occupied
    assign full      = (r_wr_ptr[c_PTR_W] != r_rd_ptr[c_PTR_W]) &&
                       (r_wr_ptr[c_PTR_W-1:0] == r_rd_ptr[c_PTR_W-1:0]);
    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign w_do_push = push && !full;
    assign w_do_pop  = pop && !empty;
    assign head      = r_mem[r_rd_ptr[c_PTR_W-1:0]];

    // Pointer update; both may move in the same edge
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // Storage write; contents need no reset since empty masks them
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[c_PTR_W-1:0]] <= din;
    end

endmodule : switch_nport_fifo
`default_nettype wire

// File: rtl/switch_nport.sv
`default_nettype none
// ============================================================================
//  Module      : switch_nport
//  Description : N-port address switch. Each accepted ingress beat is queued
//                in the FIFO of the port named by the top address bits;
//                every egress port is an independent FWFT stream whose
//                addr/data read 0 while it is empty.
//                Optional macro SWITCH_CNT_EN adds a saturating 16-bit push
//                counter per port on out_cnt.
//  Revision    : 1.0 - initial release
// ============================================================================
module switch_nport
    import switch_nport_pkg::*;
#(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16,
    parameter int NUM_PORTS  = 4,
    parameter int FIFO_DEPTH = 4
) (
    input  wire logic      clk,
    input  wire logic      rst,
    switch_nport_if.slave  bus
);

    localparam int PORT_BITS = port_bits(NUM_PORTS);

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
    } beat_t;

    logic [PORT_BITS-1:0] w_dest;
    logic [NUM_PORTS-1:0] w_full;
    logic [NUM_PORTS-1:0] w_empty;
    logic [NUM_PORTS-1:0] w_push;
    logic                 w_accept;
    beat_t                w_beat;
    beat_t                w_head [NUM_PORTS];

    assign w_dest   = PORT_BITS'(dest_index(64'(bus.in_addr), ADDR_WIDTH, PORT_BITS));
    // Ready looks only at the addressed FIFO, so one stalled port never blocks others
    assign bus.in_rdy = !w_full[w_dest];
    assign w_accept = bus.in_vld && bus.in_rdy;
    assign w_beat   = '{addr: bus.in_addr, data: bus.in_data};

    generate
        for (genvar i = 0; i < NUM_PORTS; i++) begin : g_port
            assign w_push[i] = w_accept && (w_dest == PORT_BITS'(i));

            switch_nport_fifo #(
                .WIDTH ($bits(beat_t)),
                .DEPTH (FIFO_DEPTH)
            ) u_fifo (
                .clk   (clk),
                .rst   (rst),
                .push  (w_push[i]),
                .din   (w_beat),
                .pop   (bus.out_rdy[i]),
                .full  (w_full[i]),
                .empty (w_empty[i]),
                .head  (w_head[i])
            );

            // Egress drives zeros whenever nothing is queued
            assign bus.out_vld[i] = !w_empty[i];
            assign bus.out_addr[i*ADDR_WIDTH +: ADDR_WIDTH] = w_empty[i] ? '0 : w_head[i].addr;
            assign bus.out_data[i*DATA_WIDTH +: DATA_WIDTH] = w_empty[i] ? '0 : w_head[i].data;

`ifdef SWITCH_CNT_EN
            logic [CNT_WIDTH-1:0] r_cnt;

            // Push counter that sticks at all-ones instead of wrapping
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_cnt <= '0;
                end else if (w_push[i] && (r_cnt != {CNT_WIDTH{1'b1}})) begin
                    r_cnt <= r_cnt + 1'b1;
                end
            end

            assign bus.out_cnt[i*CNT_WIDTH +: CNT_WIDTH] = r_cnt;
`endif
        end
    endgenerate

endmodule : switch_nport
`default_nettype wire

// File: tb/tb_switch_nport.sv
`default_nettype none
// ============================================================================
//  Module      : tb_switch_nport
//  Description : Self-checking bench for switch_nport (4 ports, 8-bit addr,
//                depth 4). A queue-per-port reference model predicts every
//                egress output and in_rdy each cycle. Define SWITCH_CNT_EN
//                to also exercise the saturating push counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_switch_nport;
    import switch_nport_pkg::*;

    localparam int AW = 8;
    localparam int DW = 16;
    localparam int NP = 4;
    localparam int FD = 4;

    logic clk;
    logic rst;
    int   n_chk;
    int   n_pass;

    // Reference model state
    logic [AW+DW-1:0] q [NP][$];
    int               exp_cnt [NP];
    int               n_port1_acc;

    string tag_vld  [NP] = '{"vld0",  "vld1",  "vld2",  "vld3"};
    string tag_addr [NP] = '{"addr0", "addr1", "addr2", "addr3"};
    string tag_data [NP] = '{"data0", "data1", "data2", "data3"};
    string tag_cnt  [NP] = '{"cnt0",  "cnt1",  "cnt2",  "cnt3"};

    switch_nport_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .NUM_PORTS(NP)) bus ();

    switch_nport #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .NUM_PORTS  (NP),
        .FIFO_DEPTH (FD)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        if (obs !== exp) $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        else             n_pass++;
    endtask

    // One clock: drive, compare against the model, then advance the model across the edge
    task automatic cycle(input logic r, input logic v, input logic [AW-1:0] a,
                         input logic [DW-1:0] d, input logic [NP-1:0] rdy);
        int  dst;
        logic acc;
        logic [AW+DW-1:0] hd;
        @(negedge clk);
        rst         = r;
        bus.in_vld  = v;
        bus.in_addr = a;
        bus.in_data = d;
        bus.out_rdy = rdy;
        #1;
        for (int p = 0; p < NP; p++) begin
            hd = (q[p].size() != 0) ? q[p][0] : '0;
            check(tag_vld[p],  64'(bus.out_vld[p]), 64'(q[p].size() != 0));
            check(tag_addr[p], 64'(bus.out_addr[p*AW +: AW]), 64'(hd[AW+DW-1:DW]));
            check(tag_data[p], 64'(bus.out_data[p*DW +: DW]), 64'(hd[DW-1:0]));
`ifdef SWITCH_CNT_EN
            check(tag_cnt[p], 64'(bus.out_cnt[p*16 +: 16]), 64'(exp_cnt[p]));
`endif
        end
        dst = int'(a) / (256 / NP);
        check("in_rdy", 64'(bus.in_rdy), 64'(q[dst].size() < FD));
        if (r) begin
            for (int p = 0; p < NP; p++) begin
                q[p].delete();
                exp_cnt[p] = 0;
            end
        end else begin
            acc = v && (q[dst].size() < FD);
            for (int p = 0; p < NP; p++)
                if (rdy[p] && q[p].size() != 0) void'(q[p].pop_front());
            if (acc) begin
                q[dst].push_back({a, d});
                if (exp_cnt[dst] < 65535) exp_cnt[dst]++;
                if (dst == 1) n_port1_acc++;
            end
        end
        @(posedge clk);
    endtask

    task automatic idle(input int n, input logic [NP-1:0] rdy);
        for (int k = 0; k < n; k++) cycle(1'b0, 1'b0, '0, '0, rdy);
    endtask

    initial begin
        logic [AW-1:0] ra;
        int            guard;
        n_chk = 0;
        n_pass = 0;
        n_port1_acc = 0;
        for (int p = 0; p < NP; p++) exp_cnt[p] = 0;
        rst = 1'b1;
        bus.in_vld = 1'b0;
        bus.in_addr = '0;
        bus.in_data = '0;
        bus.out_rdy = '1;
        repeat (2) @(posedge clk);

        // Reset state, then in_rdy right after release
        cycle(1'b1, 1'b0, '0, '0, '1);
        idle(1, '1);

        // Routing: one beat per port
        cycle(1'b0, 1'b1, 8'h3F, 16'd1, '1);
        cycle(1'b0, 1'b1, 8'h40, 16'd2, '1);
        cycle(1'b0, 1'b1, 8'h80, 16'd3, '1);
        cycle(1'b0, 1'b1, 8'hC5, 16'd4, '1);
        idle(2, '1);

        // Full: port 2 stalled, five pushes, then another port still accepted
        for (int k = 1; k <= 5; k++) cycle(1'b0, 1'b1, 8'h90, 16'(k), 4'b1011);
        cycle(1'b0, 1'b1, 8'h10, 16'h0AA, 4'b1011);

        // Full+pop: pop port 2 while pushing to it; push must be refused
        cycle(1'b0, 1'b1, 8'h90, 16'd5, 4'b1111);
        cycle(1'b0, 1'b1, 8'h90, 16'd5, 4'b1011);
        idle(1, 4'b1011);
        idle(6, '1);

        // Wrap: 20 beats to port 1 with toggling ready
        n_port1_acc = 0;
        guard = 0;
        while (n_port1_acc < 20 && guard < 200) begin
            ra = 8'h40 | 8'($urandom_range(0, 63));
            cycle(1'b0, 1'b1, ra, 16'(n_port1_acc + 16'h100), (guard % 2 == 0) ? 4'b0010 : 4'b0000);
            guard++;
        end
        check("wrap_done", 64'(n_port1_acc), 64'd20);
        idle(8, '1);

        // Reset mid-operation with three beats buffered at port 3
        for (int k = 0; k < 3; k++) cycle(1'b0, 1'b1, 8'hE0 | 8'(k), 16'(16'h300 + k), 4'b0111);
        cycle(1'b1, 1'b0, '0, '0, 4'b0111);
        idle(4, '1);

        // Randomised traffic
        for (int k = 0; k < 400; k++)
            cycle(1'b0, 1'($urandom_range(0, 1)), 8'($urandom), 16'($urandom), 4'($urandom));
        idle(8, '1);

`ifdef SWITCH_CNT_EN
        // Counter saturation on port 0, then clear by reset
        cycle(1'b1, 1'b0, '0, '0, '1);
        for (int k = 0; k < 70000; k++) cycle(1'b0, 1'b1, 8'h05, 16'(k), '1);
        idle(1, '1);
        check("cnt_sat", 64'(bus.out_cnt[15:0]), 64'hFFFF);
        cycle(1'b1, 1'b0, '0, '0, '1);
        idle(1, '1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule : tb_switch_nport
`default_nettype wire
